// File: rtl/dfp_pack128_seq_pkg.sv
// ---------------------------------------------------------------------------
// DFPPkg : decimal128 packed/unpacked types and encoding constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package DFPPkg;

  typedef logic [127:0] DFP128;

  typedef struct packed {
    logic         nan;
    logic         qnan;
    logic         snan;
    logic         infinity;
    logic         sign;
    logic [13:0]  exp;
    logic [135:0] sig;
  } DFP128U;

  localparam int         BIAS     = 6176;
  localparam logic [4:0] COMB_INF = 5'b11110;
  localparam logic [4:0] COMB_NAN = 5'b11111;

endpackage

`default_nettype wire

// File: rtl/dfp_pack128_seq_bcd2dpd.sv
// ---------------------------------------------------------------------------
// dfp_bcd2dpd : three BCD digits to one 10-bit densely packed declet
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dfp_bcd2dpd (
  input  logic [11:0] bcd,
  output logic [9:0]  dpd
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;

  assign a = bcd[11:8];
  assign b = bcd[7:4];
  assign c = bcd[3:0];

  // Selected by which digits are large (8 or 9); output bits are p q r s t u v w x y.
  always_comb begin
    dpd = '0;
    case ({a[3], b[3], c[3]})
      3'b000:  dpd = {a[2:0], b[2:0], 1'b0, c[2:0]};
      3'b001:  dpd = {a[2:0], b[2:0], 3'b100, c[0]};
      3'b010:  dpd = {a[2:0], c[2:1], b[0], 3'b101, c[0]};
      3'b100:  dpd = {c[2:1], a[0], b[2:0], 3'b110, c[0]};
      3'b110:  dpd = {c[2:1], a[0], 2'b00, b[0], 3'b111, c[0]};
      3'b101:  dpd = {b[2:1], a[0], 2'b01, b[0], 3'b111, c[0]};
      3'b011:  dpd = {a[2:0], 2'b10, b[0], 3'b111, c[0]};
      default: dpd = {2'b00, a[0], 2'b11, b[0], 3'b111, c[0]};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dfp_pack128_seq.sv
// ---------------------------------------------------------------------------
// dfp_pack128_seq : sequential decimal128 DPD packer, one declet per ce cycle
// Optional input check under macro DFP_PACK_BCD_CHECK_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dfp_pack128_seq
  import DFPPkg::*;
#(
  parameter int DECLETS = 11
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ce,
  input  DFP128U i,
  input  logic   i_valid,
  output logic   i_ready,
  output DFP128  o,
  output logic   o_valid,
  input  logic   o_ready,
  output logic   o_err
);

  localparam int CW = (DECLETS > 1) ? $clog2(DECLETS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENC  = 2'd1;
  localparam logic [1:0] HDR  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  DFP128U        op;
  logic [11:0]   digs;
  logic [9:0]    dpd;
  logic [4:0]    comb;

  always_comb begin
    digs = '0;
    for (int k = 0; k < DECLETS; k++) begin
      if (cnt == CW'(k)) digs = op.sig[12*k +: 12];
    end
  end

  dfp_bcd2dpd u_bcd2dpd (
    .bcd (digs),
    .dpd (dpd)
  );

  // Leading digit 8/9 keeps only its low bit; the 11 prefix marks it large.
  assign comb = op.sig[135] ? {2'b11, op.exp[13:12], op.sig[132]}
                            : {op.exp[13:12], op.sig[134:132]};

  assign o_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      o       <= '0;
      i_ready <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (i_ready && i_valid) begin
            op      <= i;
            cnt     <= '0;
            i_ready <= 1'b0;
            state   <= ENC;
          end else begin
            i_ready <= 1'b1;
          end
        end
        ENC: begin
          for (int k = 0; k < DECLETS; k++) begin
            if (cnt == CW'(k)) o[10*k +: 10] <= dpd;
          end
          if (cnt == CW'(DECLETS - 1)) state <= HDR;
          else                         cnt   <= cnt + 1'b1;
        end
        HDR: begin
          if (op.nan)           o[127:110] <= {op.sign, COMB_NAN, op.snan, 11'd0};
          else if (op.infinity) o          <= {op.sign, COMB_INF, 122'd0};
          else                  o[127:110] <= {op.sign, comb, op.exp[11:0]};
          state <= DONE;
        end
        default: begin
          if (o_ready) begin
            i_ready <= 1'b1;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef DFP_PACK_BCD_CHECK_EN
  logic bad;

  always_comb begin
    bad = (op.exp[13:12] == 2'b11);
    for (int n = 0; n < 34; n++) begin
      if (op.sig[4*n +: 4] > 4'd9) bad = 1'b1;
    end
    bad = bad & ~op.nan & ~op.infinity;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   o_err <= 1'b0;
    else if (ce && state == HDR)  o_err <= bad;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dfp_pack128_seq.sv
// ---------------------------------------------------------------------------
// tb_dfp_pack128_seq : directed + random checks against a DPD reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dfp_pack128_seq;
  import DFPPkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   ce;
  DFP128U i;
  logic   i_valid;
  logic   i_ready;
  DFP128  o;
  logic   o_valid;
  logic   o_ready;
  logic   o_err;

  int n_checks = 0;
  int n_fail   = 0;
  int enc_tab[1000];
  bit filled[1000];

`ifdef DFP_PACK_BCD_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  dfp_pack128_seq #(.DECLETS(11)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_err   (o_err)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Encoder table derived by inverting the DPD decoding rules; ascending scan keeps canonical codes.
  task automatic build_tab();
    logic [9:0] c;
    logic [3:0] a, b, d;
    int idx;
    for (int code = 0; code < 1024; code++) begin
      c = code[9:0];
      if (!c[3]) begin
        a = {1'b0, c[9:7]}; b = {1'b0, c[6:4]}; d = {1'b0, c[2:0]};
      end else begin
        case (c[2:1])
          2'b00: begin a = {1'b0, c[9:7]}; b = {1'b0, c[6:4]}; d = {3'b100, c[0]}; end
          2'b01: begin a = {1'b0, c[9:7]}; b = {3'b100, c[4]}; d = {1'b0, c[6:5], c[0]}; end
          2'b10: begin a = {3'b100, c[7]}; b = {1'b0, c[6:4]}; d = {1'b0, c[9:8], c[0]}; end
          default: begin
            case (c[6:5])
              2'b00: begin a = {3'b100, c[7]}; b = {3'b100, c[4]}; d = {1'b0, c[9:8], c[0]}; end
              2'b01: begin a = {3'b100, c[7]}; b = {1'b0, c[9:8], c[4]}; d = {3'b100, c[0]}; end
              2'b10: begin a = {1'b0, c[9:7]}; b = {3'b100, c[4]}; d = {3'b100, c[0]}; end
              default: begin a = {3'b100, c[7]}; b = {3'b100, c[4]}; d = {3'b100, c[0]}; end
            endcase
          end
        endcase
      end
      idx = 100 * int'(a) + 10 * int'(b) + int'(d);
      if (!filled[idx]) begin
        filled[idx]  = 1'b1;
        enc_tab[idx] = code;
      end
    end
  endtask

  function automatic logic [127:0] model(input DFP128U op);
    logic [127:0] r;
    int d[34];
    int idx;
    r = '0;
    for (int n = 0; n < 34; n++) d[n] = int'(op.sig[4*n +: 4]);
    if (op.nan || !op.infinity) begin
      for (int k = 0; k < 11; k++) begin
        idx = 100 * d[3*k+2] + 10 * d[3*k+1] + d[3*k];
        r[10*k +: 10] = (idx < 1000) ? 10'(enc_tab[idx]) : 10'd0;
      end
    end
    r[127] = op.sign;
    if (op.nan) begin
      r[126:122] = 5'b11111;
      r[121]     = op.snan;
    end else if (op.infinity) begin
      r[126:122] = 5'b11110;
    end else begin
      if (d[33] <= 7) r[126:122] = {op.exp[13:12], 3'(d[33])};
      else            r[126:122] = {2'b11, op.exp[13:12], 1'(d[33] % 2)};
      r[121:110] = op.exp[11:0];
    end
    return r;
  endfunction

  function automatic DFP128U rand_op(input bit allow_special);
    DFP128U r;
    int kind;
    r = '0;
    r.sign = 1'($urandom_range(0, 1));
    r.exp  = 14'($urandom_range(0, 12287));
    for (int n = 0; n < 34; n++) r.sig[4*n +: 4] = 4'($urandom_range(0, 9));
    kind = allow_special ? int'($urandom_range(0, 9)) : 9;
    if (kind == 0) begin
      r.nan      = 1'b1;
      r.snan     = 1'($urandom_range(0, 1));
      r.qnan     = ~r.snan;
      r.infinity = 1'($urandom_range(0, 1));
    end else if (kind == 1) begin
      r.infinity = 1'b1;
    end
    return r;
  endfunction

  task automatic send(input DFP128U op, input logic [127:0] exp_o, input bit chk_o,
                      input bit exp_err, input int hold, input bit rc, input bit overlap);
    int guard;
    int lat;
    int bad;
    ce = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!i_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!i_ready) check_val("ready_timeout", 1'b0, 1'b1);
    i = op;
    i_valid = 1'b1;
    do begin
      ce = rc ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end while (!ce);
    i_valid = 1'b0;
    i = rand_op(1'b1);
    lat = 1;
    guard = 0;
    while (!o_valid && guard < 200) begin
      ce = rc ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (ce) lat++;
      guard++;
    end
    ce = 1'b1;
    check_val("latency", lat, 13);
    check_val("o_valid", o_valid, 1'b1);
    if (chk_o) check_val("o_data", o, exp_o);
    check_val("o_err", o_err, exp_err);
    if (rc) begin
      ce = 1'b0;
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      ce = 1'b1;
      check_val("ce_low_hold", o_valid, 1'b1);
    end
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!o_valid || i_ready || (chk_o && o !== exp_o)) bad++;
    end
    if (hold > 0) check_val("backpressure_stable", bad, 0);
    o_ready = 1'b1;
    i_valid = overlap;
    @(negedge clk);
    o_ready = 1'b0;
    i_valid = 1'b0;
    check_val("release_valid", o_valid, 1'b0);
    check_val("release_ready", i_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    DFP128U op;
    int seen;
    build_tab();
    rst_n = 1'b0; ce = 1'b1; i = '0; i_valid = 1'b0; o_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_o", o, 128'd0);
    check_val("rst_o_valid", o_valid, 1'b0);
    check_val("rst_i_ready", i_ready, 1'b0);
    check_val("rst_o_err", o_err, 1'b0);
    rst_n = 1'b1;
    #1 check_val("rel_i_ready_low", i_ready, 1'b0);
    @(negedge clk);
    check_val("rel_i_ready_high", i_ready, 1'b1);

    op = '0; op.exp = 14'h1820;
    send(op, {16'h2208, 112'h0}, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    op.sig = 136'h999;
    send(op, {16'h2208, 112'h0FF}, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    op.sig = 136'h123;
    send(op, {16'h2208, 112'h0A3}, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    op.sig = {4'h9, 132'h0};
    send(op, {16'h6E08, 112'h0}, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    op = '0; op.infinity = 1'b1; op.sign = 1'b1; op.sig = 136'h456;
    send(op, {8'hF8, 120'h0}, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    op = '0; op.nan = 1'b1; op.qnan = 1'b1; op.infinity = 1'b1;
    send(op, {8'h7C, 120'h0}, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    op = '0; op.nan = 1'b1; op.snan = 1'b1; op.exp = 14'h1820;
    send(op, {8'h7E, 120'h0}, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    op = rand_op(1'b0);
    send(op, model(op), 1'b1, 1'b0, 20, 1'b0, 1'b1);

    op = rand_op(1'b0);
    @(negedge clk);
    i = op; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_o_valid", o_valid, 1'b0);
    check_val("midrst_o", o, 128'd0);
    check_val("midrst_i_ready", i_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check_val("midrst_no_output", seen, 0);
    check_val("midrst_ready_back", i_ready, 1'b1);

    for (int t = 0; t < 40; t++) begin
      op = rand_op(1'b1);
      send(op, model(op), 1'b1, 1'b0, int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    op = rand_op(1'b0);
    op.sig[7:4] = 4'hA;
    send(op, '0, 1'b0, ERR_EN, 0, 1'b0, 1'b0);
    op = rand_op(1'b0);
    send(op, model(op), 1'b1, 1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dfp_pack128_seq.md
DFP_PACK128_SEQ -- requirements
Module: dfp_pack128_seq

Interface
REQ-001 SHALL have parameter DECLETS, default 11, meaning number of 3-digit declets in the coefficient continuation.
REQ-002 SHALL have ports clk input 1 (system clock) and rst_n input 1 (reset, asynchronous, active-low).
REQ-003 SHALL have port ce input 1: clock enable; when low, all state holds.
REQ-004 SHALL have port i input DFP128U: unpacked operand with nan, qnan, snan, infinity, sign, exp[13:0] and sig[135:0] (34 BCD digits).
REQ-005 SHALL have ports i_valid input 1 and i_ready output 1: input handshake.
REQ-006 SHALL have port o output DFP128 (128 bits): IEEE 754-2008 decimal128 in DPD encoding.
REQ-007 SHALL have ports o_valid output 1 and o_ready input 1: output handshake.
REQ-008 SHALL have port o_err output 1: input-invalid flag, qualified by o_valid.

Function
REQ-009 SHALL implement states IDLE, ENC, HDR and DONE.
REQ-010 SHALL in IDLE assert i_ready, and on i_valid&ce capture i and enter ENC with declet counter 0.
REQ-011 SHALL in ENC encode one declet per ce cycle (BCD digits 3k+2..3k to o[10k+9:10k], k = counter, low declet first), entering HDR after k = DECLETS-1.
REQ-012 SHALL in HDR form o[127] = sign, combination o[126:122] and exponent continuation o[121:110], then enter DONE.
REQ-013 SHALL form the combination as {exp[13:12], d33[2:0]} for leading digit 0-7 and as {2'b11, exp[13:12], d33[0]} for 8-9.
REQ-014 SHALL set o[121:110] = exp[11:0] for finite values.
REQ-015 SHALL for infinity emit 0x78 in o[127:120] ORed with sign in bit 127, with all lower bits 0.
REQ-016 SHALL for NaN emit combination 11111, o[121] = snan, and the payload in the declets with leading digit ignored; precedence is nan > infinity > finite.
REQ-017 SHALL in DONE assert o_valid and hold o stable until o_ready&ce, then return to IDLE.
REQ-018 SHALL give a latency of DECLETS+2 ce cycles from input acceptance to o_valid, with one operand in flight and i_ready low outside IDLE.
REQ-019 SHALL make a simultaneous o_ready in DONE and i_valid return to IDLE only; the new operand is accepted the following cycle.

Reset
REQ-020 SHALL on rst_n low, asynchronously, enter IDLE and clear the counter, o (to 0), o_valid and o_err, with i_ready low.
REQ-021 SHALL raise i_ready in the first ce cycle after reset release.
REQ-022 SHALL discard any operand in flight when reset is applied mid-ENC or mid-HDR, with no output produced.

Configuration
REQ-023 SHALL with macro DFP_PACK_BCD_CHECK_EN defined set o_err when any sig nybble > 9 or exp[13:12] == 2'b11 on a finite operand, while still encoding per REQ-011..014.
REQ-024 SHALL without DFP_PACK_BCD_CHECK_EN tie o_err to 0 and omit the check logic.

Structure
REQ-025 SHALL take DFP128 and DFP128U typedefs, the bias constant 6176 and combination constants (INF 5'b11110, NAN 5'b11111) from DFPPkg.
REQ-026 SHALL place the 3-digit BCD-to-DPD encoder in one combinational sub-module dfp_bcd2dpd, instantiated once and time-shared across declets.

Verification
REQ-027 SHALL cover +0: sig 0, exp 0x1820 -> o = 0x2208_0000_0000_0000_0000_0000_0000_0000 after 13 ce cycles.
REQ-028 SHALL cover +1 and digits: sig low digits 0x999, then 0x123, exp 0x1820 -> o = 0x2208...00FF, then 0x2208...00A3.
REQ-029 SHALL cover leading 9: sig = 0x9 followed by 33 zero digits, exp 0x1820 -> o[127:112] = 0x6E08, all lower bits 0.
REQ-030 SHALL cover specials: -infinity -> 0xF800...0; qNaN payload 0 -> 0x7C00...0; sNaN -> 0x7E00...0.
REQ-031 SHALL cover back-pressure: o_ready low 20 cycles -> o and o_valid stable and i_ready 0; then o_ready 1 -> IDLE next cycle, with the next operand accepted cycle after.
REQ-032 SHALL cover reset and error: rst_n low at counter 5 -> o_valid 0 and no output; with DFP_PACK_BCD_CHECK_EN, a nybble 0xA in sig -> o_err 1 with o_valid.
